fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Receiving end of the fetch-stage output interface (PC, Instruction, freeze). Buffers fetched
//  {PC, Instruction} pairs in a small FIFO and hands them to the decode stage over valid/ready.
//  Drives freeze back to the fetch stage when full. Empties on a taken branch (flush).
//  Sits between the fetch stage and the ID stage. Replaces the plain IF/ID register.
// PARAMETERS
//  DEPTH  4   entries; power of two, >= 2
//  WIDTH  32  width of PC and instruction words
// PORTS
//  clk             in   1      single clock; all state updates on the rising edge
//  rst             in   1      asynchronous, active-high reset
//  if_pc           in   WIDTH  PC value from the fetch stage (PC+4 of the fetched instruction), stored unchanged
//  if_instruction  in   WIDTH  instruction from the fetch stage
//  flush           in   1      Branch_taken from EXE; discards queue contents and the current fetch
//  freeze          out  1      to fetch-stage freeze; fetch stage holds its PC while this is high
//  id_ready        in   1      decode stage accepts the head entry this cycle
//  id_valid        out  1      head entry is valid
//  id_pc           out  WIDTH  head entry PC; 0 when empty
//  id_instruction  out  WIDTH  head entry instruction; 0 when empty
//  count           out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (async, rst=1)
//   - wr_ptr, rd_ptr and count go to 0.
//   - Outputs: freeze=0, id_valid=0, id_pc=0, id_instruction=0.
//   - Storage contents are don't-care.
//  Fetch interface
//   - The fetch input is treated as valid every cycle.
//   - enq = !freeze && !flush.
//   - On enq, {if_pc, if_instruction} is written at wr_ptr, and wr_ptr increments modulo DEPTH.
//  Freeze
//   - freeze = (count==DEPTH) && !flush. Combinational from registered count and the flush input.
//   - It is never high in a flush cycle, so the fetch PC register can load BranchAddr.
//   - A frozen fetch stage re-presents the same pair. That pair is enqueued on the first cycle freeze is low, so no instruction is lost.
//  Decode interface
//   - id_valid = (count!=0). id_pc and id_instruction are the entry at rd_ptr, gated to 0 when empty.
//   - deq = id_valid && id_ready && !flush. On deq, rd_ptr increments modulo DEPTH.
//   - Head data must stay stable while id_valid && !id_ready.
//  Occupancy
//   - count += enq - deq.
//   - enq and deq in the same cycle: count unchanged, both pointers advance.
//  Full
//   - No enqueue while full, even if deq occurs in the same cycle.
//   - This gives a one-cycle bubble; it is intended, and it keeps freeze independent of id_ready.
//  Empty
//   - deq is impossible. An enqueue makes id_valid=1 in the next cycle, so minimum fetch-to-decode latency is 1 cycle.
//  Flush (priority over enq and deq)
//   - At the edge: count=0 and rd_ptr=wr_ptr=0. The current fetch pair is dropped, because it is the wrong path.
//   - id_valid=0 from the next cycle. The first branch-target pair is enqueued one cycle after the flush cycle.
//  Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally; full and empty are distinguished only by count.
//  Reset mid-operation: takes effect immediately (async) and discards all entries.
//  Width rules: no arithmetic on data; entries are stored bit-exact.
// STRUCTURE
//  - Shared defines include file: WORD_WIDTH (32) and the default queue depth.
//  - Sub-module fetch_queue_mem: DEPTH x 2*WIDTH register file.
//    One synchronous write port (we, waddr, wdata) and one combinational read port (raddr, rdata). No reset on storage.
//  - The top level holds the pointers, count, freeze/valid logic and output gating.
// TESTING
//  1. Reset then run, id_ready=1, fetch presents PC 4,8,12...
//     -> id_valid rises 1 cycle after reset release; id_pc sequence 4,8,12 in order; count stays <=1; freeze never high.
//  2. id_ready=0, continuous fetch
//     -> count 1,2,3,4, then freeze=1 with count=4 and head id_pc=4 stable.
//     Raise id_ready -> pairs dequeued in order with no loss or duplication; held fetch pair enqueued after freeze drops.
//  3. Queue at count=2, pulse flush=1 for one cycle with id_ready=1
//     -> next cycle count=0, id_valid=0, no deq of old entries; following cycle enqueues branch-target pair (e.g. PC=0x104).
//  4. Full queue (freeze=1), flush=1 in the same cycle -> freeze=0 in that cycle; next cycle count=0, pointers 0.
//  5. Wrap test, DEPTH=4: 10 enq/deq with id_ready toggling 1,0,1,1,0
//     -> output order matches input order across pointer wrap; count matches a reference model every cycle.
//  6. Assert rst asynchronously mid-cycle with count=3 -> id_valid, freeze, count and id_* outputs go to 0 before the next edge.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared word width and default depth for the fetch queue
package fetch_queue_pkg;
  localparam int WORD_WIDTH = 32;
  localparam int QUEUE_DEPTH = 4;
endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: DEPTH x W register file, one sync write port, one comb read port, no reset
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH,
  parameter int W = 2 * WORD_WIDTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: FIFO of {pc, instruction} pairs between fetch and decode, with freeze back-pressure and flush
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH,
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       if_pc,
  input  logic [WIDTH-1:0]       if_instruction,
  input  logic                   flush,
  output logic                   freeze,
  input  logic                   id_ready,
  output logic                   id_valid,
  output logic [WIDTH-1:0]       id_pc,
  output logic [WIDTH-1:0]       id_instruction,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [2*WIDTH-1:0] rdata;
  logic enq, deq;
  // Full blocks enqueue even when a dequeue happens, so freeze never depends on id_ready
  assign freeze = (count == CW'(DEPTH)) && !flush;
  assign enq = !freeze && !flush;
  assign id_valid = count != '0;
  assign deq = id_valid && id_ready && !flush;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(enq);
      rd_ptr <= rd_ptr + AW'(deq);
      count <= count + CW'(enq) - CW'(deq);
    end
  fetch_queue_mem #(.DEPTH(DEPTH), .W(2 * WIDTH)) u_mem (
    .clk  (clk),
    .we   (enq),
    .waddr(wr_ptr),
    .wdata({if_pc, if_instruction}),
    .raddr(rd_ptr),
    .rdata(rdata)
  );
  assign id_pc = id_valid ? rdata[2*WIDTH-1:WIDTH] : '0;
  assign id_instruction = id_valid ? rdata[WIDTH-1:0] : '0;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue against a small queue model and hand-computed values
module tb_fetch_queue;
  logic clk = 0, rst = 1;
  logic [31:0] pc = 32'd4, tgt = 32'h104;
  logic flush = 0, id_ready = 0;
  logic freeze, id_valid;
  logic [31:0] id_pc, id_instruction;
  logic [2:0] count;
  logic [31:0] q[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  fetch_queue dut (
    .clk(clk), .rst(rst), .if_pc(pc), .if_instruction(~pc), .flush(flush),
    .freeze(freeze), .id_ready(id_ready), .id_valid(id_valid),
    .id_pc(id_pc), .id_instruction(id_instruction), .count(count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    logic fz, en, de;
    #1;
    fz = (q.size() == 4) && !flush;
    en = !fz && !flush;
    de = (q.size() != 0) && id_ready && !flush;
    chk("freeze", {31'd0, freeze}, {31'd0, fz});
    chk("valid", {31'd0, id_valid}, {31'd0, q.size() != 0});
    chk("count", {29'd0, count}, q.size());
    chk("head_pc", id_pc, q.size() != 0 ? q[0] : 32'd0);
    chk("head_ins", id_instruction, q.size() != 0 ? ~q[0] : 32'd0);
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (de) void'(q.pop_front());
      if (en) q.push_back(pc);
    end
    #1;
    if (flush) pc = tgt;
    else if (!fz) pc = pc + 32'd4;
  endtask
  task automatic do_reset();
    rst = 1;
    flush = 0;
    id_ready = 0;
    q.delete();
    pc = 32'd4;
    #3;
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_freeze", {31'd0, freeze}, 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    do_reset();
    // 1: streaming with id_ready=1
    id_ready = 1;
    tick();
    chk("t1_pc4", id_pc, 32'd4);
    tick();
    chk("t1_pc8", id_pc, 32'd8);
    tick();
    chk("t1_pc12", id_pc, 32'd12);
    chk("t1_cnt", {29'd0, count}, 32'd1);
    repeat (3) tick();
    // 2: fill to full, then drain
    do_reset();
    repeat (4) tick();
    #1;
    chk("t2_cnt4", {29'd0, count}, 32'd4);
    chk("t2_frz", {31'd0, freeze}, 32'd1);
    chk("t2_head", id_pc, 32'd4);
    repeat (2) tick();
    chk("t2_hold_pc", pc, 32'd20);
    chk("t2_head2", id_pc, 32'd4);
    id_ready = 1;
    repeat (8) tick();
    // 3: flush at count=2
    do_reset();
    repeat (2) tick();
    id_ready = 1;
    flush = 1;
    tick();
    flush = 0;
    #1;
    chk("t3_cnt0", {29'd0, count}, 32'd0);
    chk("t3_val0", {31'd0, id_valid}, 32'd0);
    tick();
    chk("t3_tgt", id_pc, 32'h104);
    chk("t3_tgt_ins", id_instruction, ~32'h104);
    tick();
    // 4: flush while full
    do_reset();
    tgt = 32'h200;
    repeat (4) tick();
    flush = 1;
    #1;
    chk("t4_frz0", {31'd0, freeze}, 32'd0);
    tick();
    flush = 0;
    chk("t4_cnt0", {29'd0, count}, 32'd0);
    tick();
    chk("t4_tgt", id_pc, 32'h200);
    // 5: wrap-around with toggling id_ready
    do_reset();
    for (int i = 0; i < 20; i++) begin
      id_ready = (i % 5 == 1 || i % 5 == 4) ? 1'b0 : 1'b1;
      tick();
    end
    // 6: async reset mid-cycle at count=3
    do_reset();
    repeat (3) tick();
    chk("t6_cnt3", {29'd0, count}, 32'd3);
    #2;
    rst = 1;
    #1;
    chk("t6_cnt", {29'd0, count}, 32'd0);
    chk("t6_valid", {31'd0, id_valid}, 32'd0);
    chk("t6_freeze", {31'd0, freeze}, 32'd0);
    chk("t6_pc", id_pc, 32'd0);
    chk("t6_ins", id_instruction, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
